// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller that sits between a core request port and a
// single-ported, combinational-read data memory of WORDS 32-bit words.
// Handles byte, halfword and word accesses. Sub-word stores are done as a
// read-modify-write. Misaligned, illegal-size and out-of-range requests are
// rejected without touching memory.
//
// Ports
//   clk, reset_n      : single clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_write         : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr          : byte address
//   req_wdata         : store data, right-aligned
//   rsp_valid         : one-cycle completion pulse
//   rsp_rdata         : extended load data (0 for stores and errors)
//   rsp_error         : request was rejected
//   mem_address       : word-aligned memory address
//   mem_write_data    : full word to write
//   mem_write_enable  : one-cycle write strobe
//   mem_data          : combinational read data at mem_address
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_t;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;
    localparam logic [29:0] WORD_LIMIT = 30'(WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] data_q;      // extracted load value or merged store word
    logic        handshake;
    logic        req_error;

    assign handshake = req_valid && req_ready;

    // Extract the addressed byte/half from a memory word and extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Drop the right-aligned store data into the addressed lane(s).
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [31:0] wdata
    );
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            case (lane)
                2'd0:    r[7:0]   = wdata[7:0];
                2'd1:    r[15:8]  = wdata[7:0];
                2'd2:    r[23:16] = wdata[7:0];
                default: r[31:24] = wdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (lane[1]) r[31:16] = wdata[15:0];
            else         r[15:0]  = wdata[15:0];
        end else begin
            r = wdata;
        end
        return r;
    endfunction

    // Request legality, evaluated on the live request fields at acceptance.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, otherwise a missed branch infers a latch.
        req_error = 1'b0;
        case (req_size)
            SZ_HALF: req_error = req_addr[0];
            SZ_WORD: req_error = |req_addr[1:0];
            SZ_BYTE: req_error = 1'b0;
            default: req_error = 1'b1;
        endcase
        if (req_addr[31:2] >= WORD_LIMIT) req_error = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (req_error)                           state_d = ERR;
                    else if (req_write && req_size == SZ_WORD) state_d = WRITE;
                    else                                     state_d = READ;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and READ-cycle data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            data_q     <= 32'h0;
        end else begin
            if (handshake) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
            end
            if (state_q == READ) begin
                data_q <= write_q ? store_merge(mem_data, size_q, addr_q[1:0], wdata_q)
                                  : load_extract(mem_data, size_q, addr_q[1:0], unsigned_q);
            end
        end
    end

    // Output logic, purely a function of state and registered request.
    always_comb begin
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_error        = 1'b0;
        rsp_rdata        = 32'h0;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        mem_write_enable = 1'b0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            READ: mem_address = {addr_q[31:2], 2'b00};
            WRITE: begin
                mem_address      = {addr_q[31:2], 2'b00};
                mem_write_enable = 1'b1;
                // Word stores skip READ, so data_q is stale for them.
                mem_write_data   = (size_q == SZ_WORD) ? wdata_q : data_q;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (!write_q) rsp_rdata = data_q;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Directed bench for lsu_mem_ctrl with a 64-word behavioural memory.
// Inputs change just after rising edges or at falling edges; outputs are
// sampled at falling edges.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_data;

    lsu_mem_ctrl #(.WORDS(64)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_data         (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write applied on the falling
    // edge of the WRITE cycle, with a record of every write pulse.
    logic [31:0] mem [0:63];
    assign mem_data = mem[mem_address[7:2]];

    int          cyc_cnt = 0;
    int          wr_cnt  = 0;
    int          wr_cyc  = 0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;

    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (mem_write_enable) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc_cnt;
            wr_addr = mem_address;
            wr_data = mem_write_data;
            mem[mem_address[7:2]] = mem_write_data;
        end
    end

    int errors = 0;
    int checks = 0;

    // Results of the most recent issue() call.
    logic [31:0] r_rdata;
    logic        r_error;
    int          r_lat;
    int          acc_cyc;

    // Present one request, wait for acceptance, then wait for rsp_valid.
    // r_lat is the number of cycles from the accepting edge to the response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        acc_cyc = cyc_cnt;
        #1 req_valid = 1'b0;
        r_lat = 0; r_rdata = 32'hx; r_error = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r_lat = i; r_rdata = rsp_rdata; r_error = rsp_error;
                break;
            end
        end
        checks++;
        if (r_lat == 0) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h: no rsp_valid within 10 cycles", a);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        checks++;
        if ({rsp_valid, rsp_error, mem_write_enable} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000", {rsp_valid, rsp_error, mem_write_enable});
        end
        checks++;
        if ({mem_address, mem_write_data, rsp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", mem_address, mem_write_data, rsp_rdata);
        end
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_word_store();
        int w0;
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
        checks++;
        if (r_lat != 2 || r_error !== 1'b0 || r_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sw_rsp got lat=%0d err=%b rdata=%h want 2/0/0", r_lat, r_error, r_rdata);
        end
        checks++;
        if (wr_cnt - w0 != 1 || wr_cyc - acc_cyc != 1 || wr_addr !== 32'h08 || wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_write got n=%0d off=%0d addr=%h data=%h want 1/1/08/deadbeef",
                     wr_cnt - w0, wr_cyc - acc_cyc, wr_addr, wr_data);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        checks++;
        if (r_lat != 2 || r_error !== 1'b0 || r_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_back got lat=%0d err=%b rdata=%h want 2/0/deadbeef", r_lat, r_error, r_rdata);
        end
    endtask

    task automatic test_subword_store();
        int w0;
        mem[4] = 32'h11223344;
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
        checks++;
        if (r_lat != 3 || r_error !== 1'b0 || r_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_rsp got lat=%0d err=%b rdata=%h want 3/0/0", r_lat, r_error, r_rdata);
        end
        checks++;
        if (wr_cnt - w0 != 1 || wr_cyc - acc_cyc != 2 || wr_addr !== 32'h10 || wr_data !== 32'h11AB3344) begin
            errors++;
            $display("FAIL sb_write got n=%0d off=%0d addr=%h data=%h want 1/2/10/11ab3344",
                     wr_cnt - w0, wr_cyc - acc_cyc, wr_addr, wr_data);
        end
        // Upper half lane; upper bits of wdata must be ignored.
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFFBEEF);
        checks++;
        if (r_lat != 3 || mem[4] !== 32'hBEEF3344) begin
            errors++;
            $display("FAIL sh_hi got lat=%0d mem=%h want 3/beef3344", r_lat, mem[4]);
        end
        // Top byte lane.
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055);
        checks++;
        if (mem[4] !== 32'h55EF3344) begin
            errors++;
            $display("FAIL sb_lane3 got mem=%h want 55ef3344", mem[4]);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz   [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        uns  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] addr [5] = '{32'h04, 32'h05, 32'h06, 32'h06, 32'h06};
        logic [31:0] exp  [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000F0,
                                  32'hFFFF80F0, 32'h000080F0};
        mem[1] = 32'h80F0FF7F;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sz[i], uns[i], addr[i], 32'h0);
            checks++;
            if (r_lat != 2 || r_error !== 1'b0 || r_rdata !== exp[i]) begin
                errors++;
                $display("FAIL load_%0d got lat=%0d err=%b rdata=%h want 2/0/%h",
                         i, r_lat, r_error, r_rdata, exp[i]);
            end
        end
        // Last in-range word.
        mem[63] = 32'h01234567;
        issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
        checks++;
        if (r_error !== 1'b0 || r_rdata !== 32'h01234567) begin
            errors++;
            $display("FAIL lw_top got err=%b rdata=%h want 0/01234567", r_error, r_rdata);
        end
    endtask

    task automatic test_errors();
        logic        wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  sz   [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] addr [4] = '{32'h03, 32'h06, 32'h0C, 32'h100};
        int w0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(wr[i], sz[i], 1'b0, addr[i], 32'h12345678);
            checks++;
            if (r_lat != 1 || r_error !== 1'b1 || r_rdata !== 32'h0) begin
                errors++;
                $display("FAIL err_%0d got lat=%0d err=%b rdata=%h want 1/1/0",
                         i, r_lat, r_error, r_rdata);
            end
        end
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL err_nowrite got %0d writes want 0", wr_cnt - w0);
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        int rsp_seen;
        mem[8] = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01;
        req_unsigned = 1'b0; req_addr = 32'h22; req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        w0 = wr_cnt;
        checks++;
        if (mem_address !== 32'h20 || mem_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_read got addr=%h we=%b want 20/0", mem_address, mem_write_enable);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, mem_write_enable} !== 3'b100 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL abort_async got rdy/vld/we=%b addr=%h want 100/0",
                     {req_ready, rsp_valid, mem_write_enable}, mem_address);
        end
        #1 reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b want 1", req_ready);
        end
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0 || wr_cnt != w0 || mem[8] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL abort_quiet got rsp=%0d writes=%0d mem=%h want 0/0/cafef00d",
                     rsp_seen, wr_cnt - w0, mem[8]);
        end
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234);
        checks++;
        if (r_lat != 3 || r_error !== 1'b0 || mem[8] !== 32'h1234F00D) begin
            errors++;
            $display("FAIL abort_next got lat=%0d err=%b mem=%h want 3/0/1234f00d", r_lat, r_error, mem[8]);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] ready_vec;
        logic [14:0] rsp_vec;
        int          bad_data;
        ready_vec = '0; rsp_vec = '0; bad_data = 0;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            ready_vec[i] = req_ready;
            rsp_vec[i]   = rsp_valid;
            if (rsp_valid && rsp_rdata !== 32'hDEADBEEF) bad_data++;
        end
        req_valid = 1'b0;
        // Load cadence: IDLE (accept), READ, RESP, repeating.
        checks++;
        if (ready_vec !== 15'b001001001001001) begin
            errors++;
            $display("FAIL b2b_ready got %b want 001001001001001", ready_vec);
        end
        checks++;
        if (rsp_vec !== 15'b100100100100100) begin
            errors++;
            $display("FAIL b2b_rsp got %b want 100100100100100", rsp_vec);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL b2b_data got %0d bad responses want 0", bad_data);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b vld=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_word_store();
        test_subword_store();
        test_loads();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
